calc_core_param: RTL and testbench

- Parametrised calculator engine: takes decoded key codes, builds two unsigned decimal operands of up to DIGITS digits, and computes +, -, * or / (integer quotient).
- Multiply and divide are sequential (shift-add, restoring division); result is converted to BCD by sequential double-dabble.
- Drives the existing eight-digit segment display driver through per-position 5-bit symbol codes.
- Sits between the keyboard scanner (after key-to-code mapping) and the segment driver.

---
 rtl/calc_core_param.sv | 304 ++++++++++++++++++++++++++++++
 tb/tb_calc_core_param.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/calc_core_param.sv
// calc_core_param -- key-driven decimal calculator engine.
//
// Builds two unsigned decimal operands from digit keys, applies + - * /
// (integer quotient), converts the magnitude to BCD and presents the
// entry or result as per-position symbol codes for the segment driver.
//
// Ports:
//   clk        system clock
//   rst_n      asynchronous active-low reset
//   key_valid  one-cycle strobe qualifying key_code
//   key_code   0-9 digit, a + , b - , c * , d / , e = , f clear
//   seg_data   5-bit symbol per position; position 1 (leftmost) is [4:0]
//              symbols: 0-9 digit, 10 +, 12 -, 13 *, 14 /, 15 E, 16 blank, 17 r
//   busy       high while computing or converting
//   done       one-cycle pulse when a result or error is shown
//   err        high while in the error state
module calc_core_param #(
  parameter int DIGITS = 3,
  parameter int OPW    = 10,
  parameter int DISP   = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              key_valid,
  input  logic [3:0]        key_code,
  output logic [5*DISP-1:0] seg_data,
  output logic              busy,
  output logic              done,
  output logic              err
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_ENT_A = 3'd1;
  localparam logic [2:0] S_OP    = 3'd2;
  localparam logic [2:0] S_ENT_B = 3'd3;
  localparam logic [2:0] S_CALC  = 3'd4;
  localparam logic [2:0] S_CONV  = 3'd5;
  localparam logic [2:0] S_RES   = 3'd6;
  localparam logic [2:0] S_ERR   = 3'd7;

  localparam int CW = $clog2(DIGITS + 1);
  localparam int SW = $clog2(2 * OPW + 1);
  localparam int EW = 4 * DIGITS;
  localparam int MW = 2 * OPW;
  localparam int BW = 4 * DISP;
  localparam int GW = 5 * DISP;

  localparam logic [4:0] SYM_MINUS = 5'd12;
  localparam logic [4:0] SYM_E     = 5'd15;
  localparam logic [4:0] SYM_BLANK = 5'd16;
  localparam logic [4:0] SYM_R     = 5'd17;

  function automatic logic [63:0] pow10(input int n);
    logic [63:0] r;
    r = 64'd1;
    for (int i = 0; i < n; i++) r = r * 64'd10;
    return r;
  endfunction

  // Largest displayable magnitude (one position kept for the sign) and the
  // largest result that can be chained back in as operand A.
  localparam logic [63:0] OVF_LIM   = pow10(DISP - 1) - 64'd1;
  localparam logic [63:0] CHAIN_LIM = pow10(DIGITS) - 64'd1;

  function automatic logic [4:0] op_sym(input logic [1:0] op);
    logic [4:0] s;
    case (op)
      2'd0:    s = 5'd10;
      2'd1:    s = 5'd12;
      2'd2:    s = 5'd13;
      2'd3:    s = 5'd14;
      default: s = SYM_BLANK;
    endcase
    return s;
  endfunction

  // One double-dabble step: add 3 to every digit >= 5, then shift in a bit.
  function automatic logic [BW-1:0] dd_step(input logic [BW-1:0] b, input logic in_bit);
    logic [BW-1:0] t;
    t = b;
    for (int i = 0; i < DISP; i++) begin
      if (t[4*i +: 4] >= 4'd5) t[4*i +: 4] = t[4*i +: 4] + 4'd3;
    end
    return {t[BW-2:0], in_bit};
  endfunction

  // Number of significant BCD digits, at least one so zero shows as "0".
  function automatic logic [7:0] sig_digits(input logic [BW-1:0] b);
    logic [7:0] n;
    n = 8'd1;
    for (int i = 1; i < DISP; i++) begin
      if (b[4*i +: 4] != 4'd0) n = 8'(i + 1);
    end
    return n;
  endfunction

  function automatic logic [GW-1:0] render_entry(input logic [EW-1:0] ent,
                                                 input logic [CW-1:0] shown,
                                                 input logic show_op,
                                                 input logic [1:0] op);
    logic [GW-1:0] s;
    s = {DISP{SYM_BLANK}};
    for (int i = 0; i < DIGITS; i++) begin
      if (i < int'(shown)) s[5*(DISP-1-i) +: 5] = {1'b0, ent[4*i +: 4]};
    end
    if (show_op) s[4:0] = op_sym(op);
    return s;
  endfunction

  function automatic logic [GW-1:0] render_result(input logic [BW-1:0] bcd, input logic neg);
    logic [GW-1:0] s;
    logic [7:0]    n;
    s = {DISP{SYM_BLANK}};
    n = sig_digits(bcd);
    for (int i = 0; i < DISP; i++) begin
      if (i < int'(n)) s[5*(DISP-1-i) +: 5] = {1'b0, bcd[4*i +: 4]};
      else if (neg && (i == int'(n))) s[5*(DISP-1-i) +: 5] = SYM_MINUS;
    end
    return s;
  endfunction

  function automatic logic [GW-1:0] render_err();
    logic [GW-1:0] s;
    s = {DISP{SYM_BLANK}};
    s[5*(DISP-3) +: 5] = SYM_E;
    s[5*(DISP-2) +: 5] = SYM_R;
    s[5*(DISP-1) +: 5] = SYM_R;
    return s;
  endfunction

  logic [2:0]    state_q, state_d;
  logic [OPW-1:0] a_q, a_d, b_q, b_d;
  logic [CW-1:0] cnt_q, cnt_d, shown_q, shown_d;
  logic [EW-1:0] ent_q, ent_d;
  logic [1:0]    op_q, op_d;
  logic          neg_q, neg_d;
  logic [MW-1:0] mag_q, mag_d, work_q, work_d;
  logic [BW-1:0] bcd_q, bcd_d;
  logic [SW-1:0] step_q, step_d;
  logic [GW-1:0] seg_q, seg_d;
  logic          busy_q, busy_d, done_q, done_d, err_q, err_d;

  logic          clr_s, acc_s, dig_s, op_s, eq_s, to_conv_s, qbit_s;
  logic [1:0]    opc_s;
  logic [OPW:0]  rem_s;

  // Key classification; clear bypasses the busy gate, everything else waits.
  always_comb begin
    clr_s = key_valid && (key_code == 4'hf);
    acc_s = key_valid && !busy_q && (key_code != 4'hf);
    dig_s = acc_s && (key_code <= 4'd9);
    op_s  = acc_s && (key_code >= 4'ha) && (key_code <= 4'hd);
    eq_s  = acc_s && (key_code == 4'he);
    opc_s = 2'(key_code - 4'd10);
  end

  // Sequencer: operand entry, arithmetic steps and BCD conversion.
  always_comb begin
    state_d = state_q; a_d = a_q; b_d = b_q; cnt_d = cnt_q; shown_d = shown_q;
    ent_d = ent_q; op_d = op_q; neg_d = neg_q; mag_d = mag_q; work_d = work_q;
    bcd_d = bcd_q; step_d = step_q; done_d = 1'b0; to_conv_s = 1'b0;
    rem_s = {(OPW+1){1'b0}}; qbit_s = 1'b0;
    if (clr_s) begin
      state_d = S_IDLE; a_d = {OPW{1'b0}}; b_d = {OPW{1'b0}}; cnt_d = {CW{1'b0}};
      shown_d = {CW{1'b0}}; ent_d = {EW{1'b0}}; op_d = 2'd0; neg_d = 1'b0;
      mag_d = {MW{1'b0}}; work_d = {MW{1'b0}}; bcd_d = {BW{1'b0}}; step_d = {SW{1'b0}};
    end else begin
      case (state_q)
        S_IDLE, S_RES: begin
          if (dig_s) begin
            a_d = OPW'(key_code); cnt_d = CW'(1); shown_d = CW'(1);
            ent_d = EW'(key_code); state_d = S_ENT_A;
          end else if (op_s && (state_q == S_RES) && !neg_q && (64'(mag_q) <= CHAIN_LIM)) begin
            // Chain the previous result in as A; its display keeps leading zeros blanked.
            a_d = mag_q[OPW-1:0]; cnt_d = CW'(DIGITS); ent_d = bcd_q[EW-1:0];
            shown_d = CW'(sig_digits(bcd_q)); op_d = opc_s; state_d = S_OP;
          end else begin
            state_d = state_q;
          end
        end
        S_ENT_A, S_ENT_B: begin
          if (dig_s) begin
            if (cnt_q < CW'(DIGITS)) begin
              if (state_q == S_ENT_A) a_d = a_q * OPW'(4'd10) + OPW'(key_code);
              else b_d = b_q * OPW'(4'd10) + OPW'(key_code);
              cnt_d = cnt_q + CW'(1); shown_d = cnt_q + CW'(1);
              ent_d = (ent_q << 3'd4) | EW'(key_code);
            end else begin
              cnt_d = cnt_q;
            end
          end else if (op_s && (state_q == S_ENT_A)) begin
            op_d = opc_s; state_d = S_OP;
          end else if (eq_s && (state_q == S_ENT_B)) begin
            // Multiply shifts A left as the multiplicand; divide uses work as remainder.
            state_d = S_CALC; step_d = {SW{1'b0}}; mag_d = {MW{1'b0}}; neg_d = 1'b0;
            work_d = (op_q == 2'd2) ? MW'(a_q) : {MW{1'b0}};
          end else begin
            state_d = state_q;
          end
        end
        S_OP: begin
          if (op_s) begin
            op_d = opc_s;
          end else if (dig_s) begin
            b_d = OPW'(key_code); cnt_d = CW'(1); shown_d = CW'(1);
            ent_d = EW'(key_code); state_d = S_ENT_B;
          end else begin
            state_d = S_OP;
          end
        end
        S_CALC: begin
          case (op_q)
            2'd0: begin
              mag_d = MW'(a_q) + MW'(b_q); to_conv_s = 1'b1;
            end
            2'd1: begin
              neg_d = (a_q < b_q);
              mag_d = (a_q < b_q) ? MW'(b_q - a_q) : MW'(a_q - b_q);
              to_conv_s = 1'b1;
            end
            2'd2: begin
              if (b_q[0]) mag_d = mag_q + work_q;
              else mag_d = mag_q;
              work_d = work_q << 1'b1; b_d = b_q >> 1'b1;
              to_conv_s = (step_q == SW'(OPW - 1));
              step_d = step_q + SW'(1);
            end
            2'd3: begin
              if (b_q == {OPW{1'b0}}) begin
                state_d = S_ERR; done_d = 1'b1;
              end else begin
                // Restoring division: bring down the next dividend bit, trial-subtract.
                rem_s = {work_q[OPW-1:0], a_q[OPW-1]};
                if (rem_s >= {1'b0, b_q}) begin
                  rem_s = rem_s - {1'b0, b_q}; qbit_s = 1'b1;
                end else begin
                  qbit_s = 1'b0;
                end
                work_d = MW'(rem_s); a_d = {a_q[OPW-2:0], qbit_s}; mag_d = MW'(a_d);
                to_conv_s = (step_q == SW'(OPW - 1));
                step_d = step_q + SW'(1);
              end
            end
            default: state_d = S_IDLE;
          endcase
          if (to_conv_s) begin
            state_d = S_CONV; step_d = {SW{1'b0}}; work_d = mag_d; bcd_d = {BW{1'b0}};
          end else begin
            step_d = step_d;
          end
        end
        S_CONV: begin
          bcd_d = dd_step(bcd_q, work_q[MW-1]); work_d = work_q << 1'b1;
          if (step_q == SW'(MW - 1)) begin
            state_d = (64'(mag_q) > OVF_LIM) ? S_ERR : S_RES;
            done_d = 1'b1; step_d = {SW{1'b0}};
          end else begin
            step_d = step_q + SW'(1);
          end
        end
        S_ERR:   state_d = S_ERR;
        default: state_d = S_IDLE;
      endcase
    end
  end

  // Output image and status flags, computed from the next state so they
  // change in the same cycle as the state they describe.
  always_comb begin
    seg_d  = seg_q;
    busy_d = (state_d == S_CALC) || (state_d == S_CONV);
    err_d  = (state_d == S_ERR);
    case (state_d)
      S_IDLE:          seg_d = {DISP{SYM_BLANK}};
      S_ENT_A:         seg_d = render_entry(ent_d, shown_d, 1'b0, op_d);
      S_OP, S_ENT_B:   seg_d = render_entry(ent_d, shown_d, 1'b1, op_d);
      S_CALC, S_CONV:  seg_d = seg_q;
      S_RES:           seg_d = render_result(bcd_d, neg_d);
      S_ERR:           seg_d = render_err();
      default:         seg_d = {DISP{SYM_BLANK}};
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE; a_q <= {OPW{1'b0}}; b_q <= {OPW{1'b0}}; cnt_q <= {CW{1'b0}};
      shown_q <= {CW{1'b0}}; ent_q <= {EW{1'b0}}; op_q <= 2'd0; neg_q <= 1'b0;
      mag_q <= {MW{1'b0}}; work_q <= {MW{1'b0}}; bcd_q <= {BW{1'b0}}; step_q <= {SW{1'b0}};
      seg_q <= {DISP{SYM_BLANK}}; busy_q <= 1'b0; done_q <= 1'b0; err_q <= 1'b0;
    end else begin
      state_q <= state_d; a_q <= a_d; b_q <= b_d; cnt_q <= cnt_d;
      shown_q <= shown_d; ent_q <= ent_d; op_q <= op_d; neg_q <= neg_d;
      mag_q <= mag_d; work_q <= work_d; bcd_q <= bcd_d; step_q <= step_d;
      seg_q <= seg_d; busy_q <= busy_d; done_q <= done_d; err_q <= err_d;
    end
  end

  assign seg_data = seg_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign err      = err_q;

endmodule

// File: tb/tb_calc_core_param.sv
module tb_calc_core_param;

  localparam int DIGITS = 3;
  localparam int OPW    = 10;
  localparam int DISP   = 8;
  localparam int GW     = 5 * DISP;

  localparam int M_IDLE = 0, M_ENTA = 1, M_OP = 2, M_ENTB = 3, M_RES = 4, M_ERR = 5;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          key_valid;
  logic [3:0]    key_code;
  logic [GW-1:0] seg_data;
  logic          busy, done, err;

  calc_core_param #(.DIGITS(DIGITS), .OPW(OPW), .DISP(DISP)) dut (
    .clk(clk), .rst_n(rst_n), .key_valid(key_valid), .key_code(key_code),
    .seg_data(seg_data), .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    logic [GW-1:0] seg;
    logic          err;
    int            lat;
    int            issue;
  } exp_t;
  exp_t sbq[$];

  // Reference model: plain integers and a list of typed digits.
  int m_state, m_a, m_b, m_op, m_res;
  int m_txt[$];
  int m_disp[1:DISP];
  bit m_err;
  int op_sym[4] = '{10, 12, 13, 14};

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
    n_cmp++;
    if (act !== expv) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  function automatic logic [GW-1:0] pack_disp();
    logic [GW-1:0] v;
    for (int p = 1; p <= DISP; p++) v[5*(p-1) +: 5] = 5'(m_disp[p]);
    return v;
  endfunction

  task automatic set_blank();
    for (int p = 1; p <= DISP; p++) m_disp[p] = 16;
  endtask

  task automatic set_entry();
    int n;
    set_blank();
    n = m_txt.size();
    for (int j = 0; j < n; j++) m_disp[DISP - n + 1 + j] = m_txt[j];
    if (m_state == M_OP || m_state == M_ENTB) m_disp[1] = op_sym[m_op];
  endtask

  task automatic set_result(input int r);
    int v, p;
    set_blank();
    v = (r < 0) ? -r : r;
    p = DISP;
    do begin
      m_disp[p] = v % 10; v = v / 10; p--;
    end while (v > 0);
    if (r < 0) m_disp[p] = 12;
  endtask

  task automatic m_key(input int k);
    int t;
    if (k == 15) begin
      m_state = M_IDLE; m_a = 0; m_b = 0; m_op = 0; m_res = 0; m_err = 0;
      m_txt.delete(); set_blank();
      return;
    end
    case (m_state)
      M_IDLE, M_RES: begin
        if (k <= 9) begin
          m_a = k; m_txt = '{k}; m_state = M_ENTA;
        end else if (m_state == M_RES && k >= 10 && k <= 13 && m_res >= 0 && m_res <= 10**DIGITS - 1) begin
          m_a = m_res; m_op = k - 10; m_txt.delete(); t = m_res;
          do begin m_txt.push_front(t % 10); t = t / 10; end while (t > 0);
          m_state = M_OP;
        end
      end
      M_ENTA, M_ENTB: begin
        if (k <= 9 && m_txt.size() < DIGITS) begin
          if (m_state == M_ENTA) m_a = m_a * 10 + k;
          else m_b = m_b * 10 + k;
          m_txt.push_back(k);
        end else if (m_state == M_ENTA && k >= 10 && k <= 13) begin
          m_op = k - 10; m_state = M_OP;
        end
      end
      M_OP: begin
        if (k >= 10 && k <= 13) m_op = k - 10;
        else if (k <= 9) begin m_b = k; m_txt = '{k}; m_state = M_ENTB; end
      end
      default: ;
    endcase
    if (m_state == M_ENTA || m_state == M_OP || m_state == M_ENTB) set_entry();
  endtask

  // Evaluate '=' in the model; returns cycles from the '=' cycle to done.
  task automatic m_eval(output int lat);
    int r;
    if (m_op == 3 && m_b == 0) begin
      lat = 2; m_state = M_ERR; m_err = 1; set_blank();
      m_disp[DISP-2] = 15; m_disp[DISP-1] = 17; m_disp[DISP] = 17;
      return;
    end
    case (m_op)
      0: r = m_a + m_b;
      1: r = m_a - m_b;
      2: r = m_a * m_b;
      default: r = m_a / m_b;
    endcase
    lat = ((m_op < 2) ? 1 : OPW) + 2 * OPW + 1;
    if (((r < 0) ? -r : r) > 10**(DISP-1) - 1) begin
      m_state = M_ERR; m_err = 1; set_blank();
      m_disp[DISP-2] = 15; m_disp[DISP-1] = 17; m_disp[DISP] = 17;
    end else begin
      m_state = M_RES; m_res = r; m_err = 0; set_result(r);
    end
  endtask

  task automatic check_disp(input string name);
    check({name, "_seg"}, 64'(seg_data), 64'(pack_disp()));
    check({name, "_err"}, 64'(err), 64'(m_err));
  endtask

  task automatic press(input int k);
    key_valid = 1'b1; key_code = 4'(k);
    @(negedge clk);
    key_valid = 1'b0;
  endtask

  task automatic junk();
    key_valid = 1'($urandom_range(0, 1));
    key_code  = 4'($urandom_range(0, 14));
    @(negedge clk);
  endtask

  task automatic do_eq(input bit abort, input int abort_at);
    int   lat, at;
    exp_t e;
    m_eval(lat);
    e.seg = pack_disp(); e.err = m_err; e.lat = lat; e.issue = cyc;
    if (!abort) sbq.push_back(e);
    press(14);
    if (abort) begin
      at = (abort_at > 0) ? abort_at : $urandom_range(1, lat - 1);
      for (int i = 1; i < at; i++) junk();
      press(15);
      m_key(15);
      check("abort_busy", 64'(busy), 64'(0));
      check("abort_done", 64'(done), 64'(0));
      check_disp("abort");
    end else begin
      for (int i = 1; i < lat; i++) junk();
      key_valid = 1'b0;
      for (int t = 0; t < 40 && sbq.size() != 0; t++) @(negedge clk);
      if (sbq.size() != 0) begin
        check("done_timeout", 64'(sbq.size()), 64'(0));
        sbq.delete();
      end
      check_disp("result_hold");
    end
  endtask

  task automatic step(input int k, input bit abort, input int abort_at);
    if (k == 14 && m_state == M_ENTB) begin
      do_eq(abort, abort_at);
    end else begin
      press(k);
      m_key(k);
      check_disp("key");
    end
  endtask

  task automatic run_keys(input int keys[$]);
    foreach (keys[i]) step(keys[i], 1'b0, 0);
  endtask

  // Monitor: pops the scoreboard on every done pulse.
  initial begin
    int   run;
    exp_t e;
    run = 0;
    forever begin
      @(negedge clk);
      if (busy) begin
        run++;
      end else begin
        if (done) begin
          if (sbq.size() == 0) begin
            check("spurious_done", 64'(done), 64'(0));
          end else begin
            e = sbq.pop_front();
            check("res_seg", 64'(seg_data), 64'(e.seg));
            check("res_err", 64'(err), 64'(e.err));
            check("latency", 64'(cyc - e.issue), 64'(e.lat));
            check("busy_len", 64'(run), 64'(e.lat - 1));
          end
        end
        run = 0;
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL global_timeout: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    int r, k;
    rst_n = 1'b0; key_valid = 1'b0; key_code = 4'd0;
    m_key(15);
    repeat (3) @(negedge clk);
    check("rst_seg", 64'(seg_data), 64'({DISP{5'd16}}));
    check("rst_busy", 64'(busy), 64'(0));
    check("rst_done", 64'(done), 64'(0));
    check("rst_err", 64'(err), 64'(0));
    rst_n = 1'b1;
    @(negedge clk);
    check_disp("post_rst");

    run_keys('{1, 2, 10, 3, 4, 14});
    run_keys('{15, 5, 11, 1, 2, 14});
    run_keys('{15, 9, 9, 9, 12, 9, 9, 9, 14});
    run_keys('{15, 7, 13, 0, 14, 15});
    run_keys('{1, 0, 0, 13, 7, 14, 12, 2, 14});
    run_keys('{15, 9, 13, 3});
    step(14, 1'b1, 5);
    run_keys('{1, 2, 3, 4, 14, 11, 14, 15});
    run_keys('{0, 0, 7, 10, 0, 14, 10, 1, 14});

    for (int it = 0; it < 400; it++) begin
      r = $urandom_range(0, 99);
      if (r < 55)      k = $urandom_range(0, 9);
      else if (r < 72) k = $urandom_range(10, 13);
      else if (r < 94) k = 14;
      else             k = 15;
      step(k, ($urandom_range(0, 7) == 0), 0);
    end

    repeat (5) @(negedge clk);
    check("sb_empty", 64'(sbq.size()), 64'(0));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
